// File: rtl/axi_rd_req_arbiter_if.sv
// axi_rd_req_arbiter_if: AXI read-address channel between the arbiter (master) and DDR (slave).
interface axi_rd_req_arbiter_if #(
  parameter int ADDR_WIDTH = 28
);
  logic [ADDR_WIDTH-1:0] araddr;
  logic [3:0]            arid;
  logic [3:0]            arlen;
  logic                  arvalid;
  logic                  arready;
  modport master (output araddr, arid, arlen, arvalid, input arready);
  modport slave  (input araddr, arid, arlen, arvalid, output arready);
endinterface

// File: rtl/axi_rd_req_arbiter.sv
// axi_rd_req_arbiter: round-robin AR burst issue for three video read ports sharing one DDR read channel.
module axi_rd_req_arbiter #(
  parameter int ADDR_WIDTH = 28,
  parameter int DDR_DWIDTH = 256,
  parameter int BURST_LEN  = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_rd0_frame_start,
  input  logic [ADDR_WIDTH-1:0] i_rd0_base_addr,
  input  logic [CNT_WIDTH-1:0]  i_rd0_frame_bursts,
  input  logic                  i_rd0_fifo_full,
  input  logic                  i_rd1_frame_start,
  input  logic [ADDR_WIDTH-1:0] i_rd1_base_addr,
  input  logic [CNT_WIDTH-1:0]  i_rd1_frame_bursts,
  input  logic                  i_rd1_fifo_full,
  input  logic                  i_rd2_frame_start,
  input  logic [ADDR_WIDTH-1:0] i_rd2_base_addr,
  input  logic [CNT_WIDTH-1:0]  i_rd2_frame_bursts,
  input  logic                  i_rd2_fifo_full,
  input  logic                  i_ddr_fifo_full,
  output logic                  o_rd0_busy,
  output logic                  o_rd1_busy,
  output logic                  o_rd2_busy,
  output logic                  o_rd0_frame_done,
  output logic                  o_rd1_frame_done,
  output logic                  o_rd2_frame_done,
  axi_rd_req_arbiter_if.master  ar
);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(BURST_LEN * DDR_DWIDTH / 8);
  typedef enum logic {IDLE, ADDR} state_t;
  state_t                r_state;
  logic [1:0]            r_ptr, r_g, w_gnt;
  logic [ADDR_WIDTH-1:0] r_addr [3];
  logic [ADDR_WIDTH-1:0] r_pbase [3];
  logic [ADDR_WIDTH-1:0] w_base [3];
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [CNT_WIDTH-1:0]  r_rem [3];
  logic [CNT_WIDTH-1:0]  r_pbursts [3];
  logic [CNT_WIDTH-1:0]  w_bursts [3];
  logic [2:0]            r_pend, r_done, w_start, w_full, w_go, w_elig, w_busy;
  logic [3:0]            r_arid;
  logic                  r_arvalid, w_any, w_hs;

  function automatic logic [1:0] rr_idx(input logic [1:0] p, input int k);
    int s;
    s = int'(p) + k;
    return 2'(s >= 3 ? s - 3 : s);
  endfunction

  assign w_start     = {i_rd2_frame_start, i_rd1_frame_start, i_rd0_frame_start};
  assign w_full      = {i_rd2_fifo_full, i_rd1_fifo_full, i_rd0_fifo_full};
  assign w_base[0]   = i_rd0_base_addr;
  assign w_base[1]   = i_rd1_base_addr;
  assign w_base[2]   = i_rd2_base_addr;
  assign w_bursts[0] = i_rd0_frame_bursts;
  assign w_bursts[1] = i_rd1_frame_bursts;
  assign w_bursts[2] = i_rd2_frame_bursts;
  assign w_hs        = r_arvalid && ar.arready;

  assign ar.araddr  = r_araddr;
  assign ar.arid    = r_arid;
  assign ar.arlen   = 4'(BURST_LEN - 1);
  assign ar.arvalid = r_arvalid;
  assign {o_rd2_busy, o_rd1_busy, o_rd0_busy} = w_busy;
  assign {o_rd2_frame_done, o_rd1_frame_done, o_rd0_frame_done} = r_done;

  always_comb begin
    w_go   = '0;
    w_elig = '0;
    w_busy = '0;
    for (int n = 0; n < 3; n++) begin
      w_go[n]   = w_start[n] && w_bursts[n] != '0;
      w_elig[n] = r_rem[n] != '0 && !w_full[n] && !i_ddr_fifo_full && !r_pend[n];
      w_busy[n] = r_rem[n] != '0 || (r_state == ADDR && r_g == 2'(n));
    end
  end

  // Scan from the lowest priority upwards so the last hit is the first eligible after r_ptr.
  always_comb begin
    w_any = 1'b0;
    w_gnt = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      if (w_elig[rr_idx(r_ptr, k)]) begin
        w_any = 1'b1;
        w_gnt = rr_idx(r_ptr, k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= 2'd0;
      r_g       <= 2'd0;
      r_araddr  <= '0;
      r_arid    <= 4'd0;
      r_arvalid <= 1'b0;
      r_pend    <= '0;
      r_done    <= '0;
      for (int n = 0; n < 3; n++) begin
        r_addr[n]    <= '0;
        r_rem[n]     <= '0;
        r_pbase[n]   <= '0;
        r_pbursts[n] <= '0;
      end
    end else begin
      r_done <= '0;
      if (r_state == IDLE) begin
        if (w_any) begin
          r_g       <= w_gnt;
          r_araddr  <= r_addr[w_gnt];
          r_arid    <= 4'b0001 << w_gnt;
          r_arvalid <= 1'b1;
          r_state   <= ADDR;
        end
      end else if (ar.arready) begin
        r_arvalid <= 1'b0;
        r_ptr     <= r_g == 2'd2 ? 2'd0 : r_g + 2'd1;
        r_state   <= IDLE;
      end
      // A restart of the granted port waits for its handshake; the aborted frame never signals done.
      for (int n = 0; n < 3; n++) begin
        if (w_hs && r_g == 2'(n)) begin
          r_pend[n] <= 1'b0;
          if (w_go[n]) begin
            r_addr[n] <= w_base[n];
            r_rem[n]  <= w_bursts[n];
          end else if (r_pend[n]) begin
            r_addr[n] <= r_pbase[n];
            r_rem[n]  <= r_pbursts[n];
          end else begin
            r_addr[n] <= r_addr[n] + ADDR_STEP;
            r_rem[n]  <= r_rem[n] - CNT_WIDTH'(1);
            r_done[n] <= r_rem[n] == CNT_WIDTH'(1);
          end
        end else if (w_go[n] && r_state == ADDR && r_g == 2'(n)) begin
          r_pend[n]    <= 1'b1;
          r_pbase[n]   <= w_base[n];
          r_pbursts[n] <= w_bursts[n];
        end else if (w_go[n]) begin
          r_addr[n] <= w_base[n];
          r_rem[n]  <= w_bursts[n];
        end
      end
    end
  end
endmodule
